// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
// Holds the beat-buffer state enum and the lane-index width rule.
package stream_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/lane_next_sel.sv
// Finds the lowest set keep bit above (or at, with incl) a lane index.
// is_final is high when no such lane exists.
module lane_next_sel
  import stream_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int IW    = lane_idx_w(RATIO)
) (
  input  logic [RATIO-1:0] keep,
  input  logic [IW-1:0]    idx,
  input  logic             incl,
  output logic [IW-1:0]    next,
  output logic             is_final
);

  // Walk downward so the lowest qualifying lane wins.
  always_comb begin
    next     = '0;
    is_final = 1'b1;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (keep[i] &&
          ((i > int'(idx)) ||
           (incl && (i == int'(idx))))) begin
        next     = IW'(i);
        is_final = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one buffered beat,
// emitted lane by lane, skipping lanes whose keep bit is clear.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IW = lane_idx_w(T_DATA_RATIO);

  state_t                  state;
  logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] buf_keep;
  logic                    buf_last;
  logic [IW-1:0]           idx;

  logic [IW-1:0] next_idx;
  logic          is_final;
  logic [IW-1:0] first_idx;
  logic          keep_none;
  logic          s_hs;

  lane_next_sel #(
    .RATIO (T_DATA_RATIO),
    .IW    (IW)
  ) u_buf_sel (
    .keep     (buf_keep),
    .idx      (idx),
    .incl     (1'b0),
    .next     (next_idx),
    .is_final (is_final)
  );

  // Searching from lane 0 inclusive gives the first lane of a new beat.
  lane_next_sel #(
    .RATIO (T_DATA_RATIO),
    .IW    (IW)
  ) u_in_sel (
    .keep     (s_keep_i),
    .idx      ('0),
    .incl     (1'b1),
    .next     (first_idx),
    .is_final (keep_none)
  );

  always_comb begin
    s_ready_o = 1'b0;
    if (!rst_n) begin
      s_ready_o = (state == EMPTY) ||
                  (m_ready_i && is_final);
    end
  end

  assign s_hs      = s_valid_i && s_ready_o;
  assign m_valid_o = (state == SEND);
  assign m_last_o  = (state == SEND) && is_final && buf_last;

  always_comb begin
    m_data_o = '0;
    if (state == SEND) begin
      m_data_o = buf_data[idx];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= EMPTY;
      buf_keep <= '0;
      buf_last <= 1'b0;
      idx      <= '0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        buf_data[i] <= '0;
      end
    end else if (s_hs) begin
      // In SEND a beat is only accepted on the final-lane handshake.
      if (!keep_none) begin
        state    <= SEND;
        buf_data <= s_data_i;
        buf_keep <= s_keep_i;
        buf_last <= s_last_i;
        idx      <= first_idx;
      end else begin
        state <= EMPTY;
      end
    end else if (state == SEND && m_ready_i) begin
      if (is_final) begin
        state <= EMPTY;
      end else begin
        idx <= next_idx;
      end
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Bench for stream_downsize: cycle table, corner sequences,
// then random traffic against a word-queue reference model.
module tb_stream_downsize;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data [4];
  logic [3:0] s_keep;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  int vectors;
  int miscompares;

  stream_downsize #(
    .T_DATA_WIDTH (8),
    .T_DATA_RATIO (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  word_t q[$];

  typedef struct {
    logic            valid;
    logic [3:0]      keep;
    logic            last;
    logic [3:0][7:0] d;
    logic            mr;
    logic            e_valid;
    logic [7:0]      e_data;
    logic            e_last;
    logic            e_ready;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (rst_n) return 1'b0;
    return (q.size() == 0) ||
           (m_ready && q.size() == 1);
  endfunction

  task automatic push_beat(input logic [3:0] k,
                           input logic [3:0][7:0] d,
                           input logic l);
    int hi;
    word_t w;
    hi = -1;
    for (int i = 0; i < 4; i++) if (k[i]) hi = i;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) begin
        w.data = d[i];
        w.last = l && (i == hi);
        q.push_back(w);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] k,
                       input logic l, input logic [3:0][7:0] d,
                       input logic mr);
    s_valid = v;
    s_keep  = k;
    s_last  = l;
    for (int i = 0; i < 4; i++) s_data[i] = d[i];
    m_ready = mr;
    #1;
  endtask

  task automatic check_model();
    logic ev;
    ev = !rst_n && (q.size() != 0);
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("m_data", 32'(m_data), ev ? 32'(q[0].data) : 32'd0);
    chk("m_last", 32'(m_last), ev ? 32'(q[0].last) : 32'd0);
    chk("s_ready", 32'(s_ready), 32'(exp_ready()));
  endtask

  task automatic tick();
    logic            shs;
    logic            mhs;
    logic [3:0]      k;
    logic [3:0][7:0] d;
    logic            l;
    shs = s_valid && exp_ready();
    mhs = !rst_n && (q.size() != 0) && m_ready;
    k = s_keep;
    l = s_last;
    for (int i = 0; i < 4; i++) d[i] = s_data[i];
    @(posedge clk);
    if (rst_n) begin
      q.delete();
    end else begin
      if (mhs) void'(q.pop_front());
      if (shs) push_beat(k, d, l);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] k,
                              input logic l, input logic mr,
                              input logic ev, input logic [7:0] ed,
                              input logic el, input logic er);
    vec_t t;
    t.valid = v; t.keep = k; t.last = l;
    t.d = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    t.mr = mr;
    t.e_valid = ev; t.e_data = ed;
    t.e_last = el; t.e_ready = er;
    return t;
  endfunction

  logic [3:0][7:0] dabcd;
  logic [3:0][7:0] dz;

  initial begin
    vectors = 0;
    miscompares = 0;
    dabcd = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    dz = '0;
    rst_n = 1'b1;
    drive(0, 4'h0, 0, dz, 0);
    @(negedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rel_s_ready", 32'(s_ready), 1);

    // Full beat, then sparse beat 1010.
    tbl.push_back(mk(1, 4'hF, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hAA, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hBB, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hCC, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hDD, 1, 1));
    tbl.push_back(mk(1, 4'hA, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hBB, 0, 0));
    tbl.push_back(mk(0, 4'h0, 0, 1, 1, 8'hDD, 1, 1));
    tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 0, 1));
    foreach (tbl[n]) begin
      drive(tbl[n].valid, tbl[n].keep, tbl[n].last,
            tbl[n].d, tbl[n].mr);
      chk("tbl_valid", 32'(m_valid), 32'(tbl[n].e_valid));
      chk("tbl_data", 32'(m_data), 32'(tbl[n].e_data));
      chk("tbl_last", 32'(m_last), 32'(tbl[n].e_last));
      chk("tbl_ready", 32'(s_ready), 32'(tbl[n].e_ready));
      check_model();
      tick();
    end

    // Back-to-back full beats with s_valid held high.
    begin
      logic [3:0][7:0] b [2];
      int bi;
      logic hs;
      b[0] = {8'h14, 8'h13, 8'h12, 8'h11};
      b[1] = {8'h24, 8'h23, 8'h22, 8'h21};
      bi = 0;
      for (int c = 0; c < 10; c++) begin
        drive(bi < 2, 4'hF, 1, b[bi < 2 ? bi : 1], 1);
        check_model();
        if (c >= 1 && c <= 8) begin
          chk("b2b_gap", 32'(m_valid), 1);
          chk("b2b_ready", 32'(s_ready), 32'(c == 4 || c == 8));
        end
        hs = (bi < 2) && exp_ready();
        tick();
        if (hs) bi++;
      end
    end

    // Stall three cycles mid-beat.
    drive(1, 4'hF, 0, dabcd, 1);
    check_model();
    tick();
    drive(0, 4'h0, 0, dz, 1);
    check_model();
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 4'hF, 0, dz, 0);
      check_model();
      chk("stall_data", 32'(m_data), 32'h00BB);
      chk("stall_ready", 32'(s_ready), 0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 4'h0, 0, dz, 1);
      check_model();
      tick();
    end
    chk("stall_drained", 32'(q.size()), 0);

    // Empty-keep beat is dropped, next beat flows.
    drive(1, 4'h0, 1, dabcd, 1);
    check_model();
    tick();
    drive(1, 4'h4, 1, dabcd, 1);
    chk("k0_valid", 32'(m_valid), 0);
    chk("k0_ready", 32'(s_ready), 1);
    check_model();
    tick();
    drive(0, 4'h0, 0, dz, 1);
    chk("k0_next", 32'(m_data), 32'h00CC);
    chk("k0_last", 32'(m_last), 1);
    check_model();
    tick();

    // Reset with two words outstanding.
    drive(1, 4'hF, 1, dabcd, 1);
    tick();
    drive(0, 4'h0, 0, dz, 1);
    tick();
    tick();
    chk("pre_rst_data", 32'(m_data), 32'h00CC);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_ready", 32'(s_ready), 0);
    check_model();
    tick();
    rst_n = 1'b0;
    drive(1, 4'hF, 1, {8'h44, 8'h33, 8'h22, 8'h11}, 1);
    chk("post_rst_ready", 32'(s_ready), 1);
    check_model();
    tick();
    drive(0, 4'h0, 0, dz, 1);
    chk("post_rst_lane0", 32'(m_data), 32'h0011);
    check_model();
    tick();

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      logic [3:0][7:0] rd;
      rd = {$urandom, $urandom} ;
      drive($urandom_range(0, 3) != 0,
            4'($urandom), 1'($urandom),
            rd, $urandom_range(0, 3) != 0);
      check_model();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_downsize.md
STREAM_DOWNSIZE -- requirements
Module: stream_downsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, width in bits of one narrow word / one lane.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of lanes per wide input beat (>=2).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_data_i  input  [T_DATA_WIDTH-1:0] x T_DATA_RATIO (unpacked array)  wide beat, lane 0 = first word in stream order.
REQ-006 SHALL have port s_keep_i  input  T_DATA_RATIO  per-lane valid mask.
REQ-007 SHALL have port s_last_i  input  1  final beat of packet.
REQ-008 SHALL have port s_valid_i  input  1  wide beat present.
REQ-009 SHALL have port s_ready_o  output  1  block can accept a wide beat.
REQ-010 SHALL have port m_data_o  output  T_DATA_WIDTH  narrow word.
REQ-011 SHALL have port m_last_o  output  1  final word of packet.
REQ-012 SHALL have port m_valid_o  output  1  narrow word present.
REQ-013 SHALL have port m_ready_i  input  1  downstream accepts word.

Function
REQ-014 Transfer SHALL occur on a side only when valid and ready are both 1 on a rising clk edge.
REQ-015 Accepted beat SHALL be captured into an internal beat buffer (data, keep, last); states EMPTY and SEND.
REQ-016 EMPTY -> SEND on accepted beat with s_keep_i != 0; lane index SHALL load the lowest set keep bit.
REQ-017 Accepted beat with s_keep_i == 0 SHALL be discarded entirely (including s_last_i), state stays EMPTY.
REQ-018 In SEND, m_valid_o SHALL be 1 and m_data_o SHALL equal buffered lane at current index; in EMPTY m_valid_o=0, m_data_o=0.
REQ-019 On output handshake, index SHALL advance to the next higher set keep bit, skipping cleared lanes.
REQ-020 Final lane = no set keep bit above current index; m_last_o SHALL be 1 only on final lane of a beat buffered with last=1.
REQ-021 Handshake on final lane with no new beat accepted SHALL return to EMPTY.
REQ-022 s_ready_o SHALL be 1 in EMPTY, or in SEND when m_ready_i=1 and current lane is final (combinational on m_ready_i only); else 0.
REQ-023 Beat accepted in the same cycle as final-lane handshake SHALL load directly, giving zero bubble between beats.
REQ-024 Latency SHALL be one cycle: beat accepted at edge N -> first word valid after edge N.
REQ-025 Throughput SHALL be one word per cycle; a beat with k set keep bits SHALL occupy exactly k output cycles under m_ready_i=1.
REQ-026 m_data_o/m_last_o/m_valid_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-027 m_* outputs SHALL depend on registers only; no combinational path from any s_* input to m_*.

Reset
REQ-028 While rst_n=1: state EMPTY, buffer and index cleared, m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=0.
REQ-029 Reset mid-packet SHALL drop buffered beat; first cycle after release s_ready_o=1.

Structure
REQ-030 Shared package stream_pkg SHALL hold the lane-index width constant ($clog2(T_DATA_RATIO)) helper and the state enum {EMPTY, SEND}.
REQ-031 Next-set-lane search SHALL be a sub-module lane_next_sel (keep mask, current index -> next index, is_final flag, pure combinational).

Verification
REQ-032 Beat data {D,C,B,A}, keep 4'b1111, last=1, m_ready_i=1 -> A,B,C,D on 4 consecutive cycles, m_last_o only with D.
REQ-033 Keep 4'b1010, data {D,C,B,A}, last=1 -> words B,D only, m_last_o with D, s_ready_o=1 on D cycle.
REQ-034 Two back-to-back full beats, s_valid_i held 1 -> 8 words with no m_valid_o gap, s_ready_o pulses 1 on each final lane.
REQ-035 m_ready_i=0 for 3 cycles mid-beat -> m_data_o/m_valid_o frozen, s_ready_o=0, no word lost or duplicated.
REQ-036 Beat keep 4'b0000, last=1 accepted -> no m_valid_o, s_ready_o stays 1, following beat output normally.
REQ-037 rst_n=1 asserted while 2 words outstanding -> m_valid_o=0 immediately; after release next beat output from its lane 0.
